// File: rtl/int_alu_seq_pkg.sv
// Shared opcodes, FSM states and decode helpers for the int_alu_seq execute unit.
package int_alu_seq_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLL    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_LT     = 5'd8,
      ALU_LTU    = 5'd9,
      ALU_EQ     = 5'd10,
      ALU_DIV    = 5'd11,
      ALU_DIVU   = 5'd12,
      ALU_REM    = 5'd13,
      ALU_REMU   = 5'd14,
      ALU_MUL    = 5'd15,
      ALU_MULH   = 5'd16,
      ALU_MULHSU = 5'd17,
      ALU_MULHU  = 5'd18
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_MUL  = 2'd3
   } state_e;

   function automatic logic is_div_op(input logic [4:0] op);
      return (op >= ALU_DIV) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_mul_op(input logic [4:0] op);
      return (op >= ALU_MUL) && (op <= ALU_MULHU);
   endfunction

endpackage

// File: rtl/int_alu_seq_if.sv
// Issue-side and writeback-side handshake bundle of int_alu_seq.
interface int_alu_seq_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_op;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_y;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_y, out_tag
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_y, out_tag
   );
endinterface

// File: rtl/int_alu_seq_div_iter.sv
// Unsigned restoring radix-2 divider datapath: one quotient bit per cycle, XLEN cycles.
module int_div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o,
   output logic            last_o
);
   localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [XLEN:0]    shifted_s, diff_s;

   // Quotient register doubles as the dividend shift-out source.
   assign shifted_s = {rem_q, quo_q[XLEN-1]};
   assign diff_s    = shifted_s - {1'b0, dvs_q};

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      if (clear_i) begin
         cnt_d  = {CNT_W{1'b0}};
         busy_d = 1'b0;
      end else if (start_i) begin
         cnt_d  = CNT_W'(XLEN - 1);
         busy_d = 1'b1;
         quo_d  = dividend_i;
         rem_d  = {XLEN{1'b0}};
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         rem_d  = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
         quo_d  = {quo_q[XLEN-2:0], ~diff_s[XLEN]};
         cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         busy_d = (cnt_q != {CNT_W{1'b0}});
      end else begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {CNT_W{1'b0}};
         busy_q <= 1'b0;
         quo_q  <= {XLEN{1'b0}};
         rem_q  <= {XLEN{1'b0}};
         dvs_q  <= {XLEN{1'b0}};
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign quo_o  = quo_q;
   assign rem_o  = rem_q;
   assign last_o = busy_q && (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/int_alu_seq.sv
// Handshaked integer execute unit: 1-cycle base ops, iterative divider, optional
// multiplier enabled by defining INT_ALU_MUL_EN.
module int_alu_seq
   import int_alu_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   int_alu_seq_if.slave bus
);
   localparam int SH_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_y_q, out_y_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d, tag_q, tag_d;
   logic             negq_q, negq_d, negr_q, negr_d, sel_rem_q, sel_rem_d;

   alu_op_e          op_s;
   logic             accept_s, is_div_s, signed_s, is_rem_s, a_neg_s, b_neg_s;
   logic             div_zero_s, div_ovf_s, special_s, div_start_s, div_last_s;
   logic [SH_W-1:0]  shamt_s;
   logic [XLEN-1:0]  a_s, b_s, a_mag_s, b_mag_s, alu_y_s, special_y_s, fix_y_s;
   logic [XLEN-1:0]  div_quo_s, div_rem_s;

   assign a_s          = bus.in_a;
   assign b_s          = bus.in_b;
   assign op_s         = alu_op_e'(bus.in_op);
   assign shamt_s      = b_s[SH_W-1:0];
   assign bus.in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept_s     = bus.in_valid && bus.in_ready;

   assign is_div_s    = is_div_op(bus.in_op);
   assign signed_s    = (op_s == ALU_DIV) || (op_s == ALU_REM);
   assign is_rem_s    = (op_s == ALU_REM) || (op_s == ALU_REMU);
   assign a_neg_s     = signed_s && a_s[XLEN-1];
   assign b_neg_s     = signed_s && b_s[XLEN-1];
   assign a_mag_s     = a_neg_s ? -a_s : a_s;
   assign b_mag_s     = b_neg_s ? -b_s : b_s;
   assign div_zero_s  = (b_s == {XLEN{1'b0}});
   assign div_ovf_s   = signed_s && (a_s == MIN_V) && (b_s == {XLEN{1'b1}});
   assign special_s   = is_div_s && (div_zero_s || div_ovf_s);
   assign div_start_s = accept_s && is_div_s && !special_s && !flush;

   // Single-cycle results; MUL* fall into default when the multiplier is absent.
   always_comb begin
      alu_y_s = {XLEN{1'b0}};
      case (op_s)
         ALU_ADD: alu_y_s = a_s + b_s;
         ALU_SUB: alu_y_s = a_s - b_s;
         ALU_AND: alu_y_s = a_s & b_s;
         ALU_OR:  alu_y_s = a_s | b_s;
         ALU_XOR: alu_y_s = a_s ^ b_s;
         ALU_SLL: alu_y_s = a_s << shamt_s;
         ALU_SRL: alu_y_s = a_s >> shamt_s;
         ALU_SRA: alu_y_s = $signed(a_s) >>> shamt_s;
         ALU_LT:  alu_y_s = {{(XLEN-1){1'b0}}, $signed(a_s) < $signed(b_s)};
         ALU_LTU: alu_y_s = {{(XLEN-1){1'b0}}, a_s < b_s};
         ALU_EQ:  alu_y_s = {{(XLEN-1){1'b0}}, a_s == b_s};
         default: alu_y_s = {XLEN{1'b0}};
      endcase
   end

   always_comb begin
      special_y_s = {XLEN{1'b0}};
      if (div_zero_s) begin
         special_y_s = is_rem_s ? a_s : {XLEN{1'b1}};
      end else if (div_ovf_s) begin
         special_y_s = is_rem_s ? {XLEN{1'b0}} : MIN_V;
      end else begin
         special_y_s = {XLEN{1'b0}};
      end
   end

   int_div_iter #(.XLEN(XLEN)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (flush),
      .start_i    (div_start_s),
      .dividend_i (a_mag_s),
      .divisor_i  (b_mag_s),
      .quo_o      (div_quo_s),
      .rem_o      (div_rem_s),
      .last_o     (div_last_s)
   );

   assign fix_y_s = sel_rem_q ? (negr_q ? -div_rem_s : div_rem_s)
                              : (negq_q ? -div_quo_s : div_quo_s);

`ifdef INT_ALU_MUL_EN
   logic [XLEN:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic              mul_hi_q, mul_hi_d;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   mul_y_s;

   // Operands are pre-extended by one bit so one signed product covers all four variants.
   assign prod_s  = {{(XLEN-1){mul_a_q[XLEN]}}, mul_a_q} * {{(XLEN-1){mul_b_q[XLEN]}}, mul_b_q};
   assign mul_y_s = mul_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a_q  <= {(XLEN+1){1'b0}};
         mul_b_q  <= {(XLEN+1){1'b0}};
         mul_hi_q <= 1'b0;
      end else begin
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_hi_q <= mul_hi_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
      tag_d       = tag_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      sel_rem_d   = sel_rem_q;
`ifdef INT_ALU_MUL_EN
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_hi_d    = mul_hi_q;
`endif
      if (flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && is_div_s && !special_s) begin
                  state_d   = ST_DIV;
                  tag_d     = bus.in_tag;
                  negq_d    = a_neg_s ^ b_neg_s;
                  negr_d    = a_neg_s;
                  sel_rem_d = is_rem_s;
`ifdef INT_ALU_MUL_EN
               end else if (accept_s && is_mul_op(bus.in_op)) begin
                  state_d  = ST_MUL;
                  tag_d    = bus.in_tag;
                  mul_a_d  = {(op_s != ALU_MULHU) && a_s[XLEN-1], a_s};
                  mul_b_d  = {((op_s == ALU_MUL) || (op_s == ALU_MULH)) && b_s[XLEN-1], b_s};
                  mul_hi_d = (op_s != ALU_MUL);
`endif
               end else if (accept_s) begin
                  out_valid_d = 1'b1;
                  out_y_d     = special_s ? special_y_s : alu_y_s;
                  out_tag_d   = bus.in_tag;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DIV: begin
               if (div_last_s) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_DIV;
               end
            end
            ST_FIX: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b1;
               out_y_d     = fix_y_s;
               out_tag_d   = tag_q;
            end
`ifdef INT_ALU_MUL_EN
            ST_MUL: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b1;
               out_y_d     = mul_y_s;
               out_tag_d   = tag_q;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_y_q     <= {XLEN{1'b0}};
         out_tag_q   <= {TAG_W{1'b0}};
         tag_q       <= {TAG_W{1'b0}};
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         sel_rem_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_tag_q   <= out_tag_d;
         tag_q       <= tag_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
         sel_rem_q   <= sel_rem_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_tag   = out_tag_q;
endmodule
